// File: rtl/deque_arbiter.sv
// Shared circular-buffer deque serving NREQ requesters.
// Round-robin grant; one push/pop executes per clock.
module deque_arbiter #(
  parameter int NREQ  = 4,
  parameter int DW    = 32,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH),
  localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic               clk,
  input  logic               rst_h,
  input  logic               flush_i,
  input  logic [NREQ-1:0]    req_i,
  input  logic [2*NREQ-1:0]  op_i,
  input  logic [DW*NREQ-1:0] wdata_i,
  output logic [NREQ-1:0]    gnt_o,
  output logic               rvalid_o,
  output logic [IW-1:0]      rid_o,
  output logic [DW-1:0]      rdata_o,
  output logic [AW:0]        count_o,
  output logic               full_o,
  output logic               empty_o
);

  localparam logic [1:0] OP_PUSH_B = 2'b00;
  localparam logic [1:0] OP_PUSH_F = 2'b01;
  localparam logic [1:0] OP_POP_B  = 2'b10;
  localparam logic [1:0] OP_POP_F  = 2'b11;

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [AW:0]   r_count;
  logic [IW-1:0] r_rr;
  logic          r_rvalid;
  logic [IW-1:0] r_rid;
  logic [DW-1:0] r_rdata;

  logic            w_full;
  logic            w_empty;
  logic [NREQ-1:0] w_elig;
  logic            w_any;
  logic [IW-1:0]   w_sel;
  int              w_idx;
  logic [1:0]      w_op;
  logic [DW-1:0]   w_wd;
  logic [AW-1:0]   w_waddr;
  logic [AW-1:0]   w_raddr;
  logic [IW-1:0]   w_rr_nxt;

  assign w_full  = (r_count == (AW+1)'(DEPTH));
  assign w_empty = (r_count == '0);

  // Pops need data, pushes need room; others are skipped.
  always_comb begin
    for (int k = 0; k < NREQ; k++) begin
      w_elig[k] = req_i[k] &
        (op_i[2*k+1] ? ~w_empty : ~w_full);
    end
  end

  always_comb begin
    w_any = 1'b0;
    w_sel = '0;
    w_idx = 0;
    for (int i = 0; i < NREQ; i++) begin
      w_idx = (int'(r_rr) + i) % NREQ;
      if (!w_any && w_elig[w_idx]) begin
        w_any = 1'b1;
        w_sel = IW'(w_idx);
      end
    end
    if (rst_h || flush_i) begin
      w_any = 1'b0;
    end
  end

  assign gnt_o = w_any ? (NREQ'(1) << w_sel) : '0;

  assign w_op    = op_i[2*w_sel +: 2];
  assign w_wd    = wdata_i[DW*w_sel +: DW];
  assign w_waddr = w_op[0] ? r_head - 1'b1 : r_tail;
  assign w_raddr = w_op[0] ? r_head : r_tail - 1'b1;

  assign w_rr_nxt = (w_sel == IW'(NREQ-1)) ?
    '0 : w_sel + 1'b1;

  always_ff @(posedge clk) begin
    if (w_any && !w_op[1]) begin
      r_mem[w_waddr] <= w_wd;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_h) begin
      r_head   <= '0;
      r_tail   <= '0;
      r_count  <= '0;
      r_rr     <= '0;
      r_rvalid <= 1'b0;
      r_rid    <= '0;
      r_rdata  <= '0;
    end else if (flush_i) begin
      r_head   <= '0;
      r_tail   <= '0;
      r_count  <= '0;
      r_rvalid <= 1'b0;
    end else begin
      r_rvalid <= 1'b0;
      if (w_any) begin
        r_rr <= w_rr_nxt;
        unique case (w_op)
          OP_PUSH_B: begin
            r_tail  <= r_tail + 1'b1;
            r_count <= r_count + 1'b1;
          end
          OP_PUSH_F: begin
            r_head  <= r_head - 1'b1;
            r_count <= r_count + 1'b1;
          end
          OP_POP_B: begin
            r_tail   <= r_tail - 1'b1;
            r_count  <= r_count - 1'b1;
            r_rvalid <= 1'b1;
            r_rid    <= w_sel;
            r_rdata  <= r_mem[w_raddr];
          end
          OP_POP_F: begin
            r_head   <= r_head + 1'b1;
            r_count  <= r_count - 1'b1;
            r_rvalid <= 1'b1;
            r_rid    <= w_sel;
            r_rdata  <= r_mem[w_raddr];
          end
          default: ;
        endcase
      end
    end
  end

  assign rvalid_o = r_rvalid;
  assign rid_o    = r_rid;
  assign rdata_o  = r_rdata;
  assign count_o  = r_count;
  assign full_o   = w_full;
  assign empty_o  = w_empty;

endmodule

// File: tb/tb_deque_arbiter.sv
// Bench for deque_arbiter: queue-based reference model,
// directed scenarios plus randomized traffic.
module tb_deque_arbiter;

  logic         clk = 1'b0;
  logic         rst_h;
  logic         flush_i;
  logic [3:0]   req_i;
  logic [7:0]   op_i;
  logic [127:0] wdata_i;
  logic [3:0]   gnt_o;
  logic         rvalid_o;
  logic [1:0]   rid_o;
  logic [31:0]  rdata_o;
  logic [4:0]   count_o;
  logic         full_o;
  logic         empty_o;

  deque_arbiter dut (
    .clk(clk), .rst_h(rst_h), .flush_i(flush_i),
    .req_i(req_i), .op_i(op_i), .wdata_i(wdata_i),
    .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rid_o(rid_o),
    .rdata_o(rdata_o), .count_o(count_o),
    .full_o(full_o), .empty_o(empty_o)
  );

  always #5 clk = ~clk;

  logic [31:0] q[$];
  int          m_rr;
  logic        m_rvalid;
  logic [1:0]  m_rid;
  logic [31:0] m_rdata;
  int          n_vec = 0;
  int          n_err = 0;
  logic [3:0]  g;

  task automatic chk(string nm, logic [63:0] act,
                     logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic idle();
    req_i   = '0;
    op_i    = '0;
    wdata_i = '0;
    flush_i = 1'b0;
    rst_h   = 1'b0;
  endtask

  task automatic set_req(int k, logic [1:0] op,
                         logic [31:0] d);
    req_i[k]        = 1'b1;
    op_i[2*k +: 2]  = op;
    wdata_i[32*k +: 32] = d;
  endtask

  // Compare this cycle against the model, then advance both.
  task automatic step(output logic [3:0] gs);
    int         win;
    logic [3:0] eg;
    logic [1:0] op;
    logic [31:0] d;
    #1;
    win = -1;
    eg  = '0;
    if (!rst_h && !flush_i) begin
      for (int i = 0; i < 4; i++) begin
        int k;
        k = (m_rr + i) % 4;
        if (win < 0 && req_i[k] &&
            (op_i[2*k+1] ? q.size() > 0 : q.size() < 16))
          win = k;
      end
    end
    if (win >= 0) eg[win] = 1'b1;
    gs = gnt_o;
    chk("gnt", 64'(gnt_o), 64'(eg));
    chk("count", 64'(count_o), 64'(q.size()));
    chk("full", 64'(full_o), 64'(q.size() == 16));
    chk("empty", 64'(empty_o), 64'(q.size() == 0));
    chk("rvalid", 64'(rvalid_o), 64'(m_rvalid));
    chk("rid", 64'(rid_o), 64'(m_rid));
    chk("rdata", 64'(rdata_o), 64'(m_rdata));
    if (rst_h) begin
      q.delete();
      m_rr = 0; m_rvalid = 0; m_rid = 0; m_rdata = 0;
    end else if (flush_i) begin
      q.delete();
      m_rvalid = 0;
    end else begin
      m_rvalid = 0;
      if (win >= 0) begin
        op = op_i[2*win +: 2];
        d  = wdata_i[32*win +: 32];
        case (op)
          2'b00: q.push_back(d);
          2'b01: q.push_front(d);
          2'b10: m_rdata = q.pop_back();
          default: m_rdata = q.pop_front();
        endcase
        if (op[1]) begin
          m_rvalid = 1;
          m_rid = 2'(win);
        end
        m_rr = (win + 1) % 4;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst_h = 1'b1;
    step(g);
    idle();
  endtask

  initial begin
    int pop_pct;
    idle();
    rst_h = 1'b1;
    q.delete();
    m_rr = 0; m_rvalid = 0; m_rid = 0; m_rdata = 0;
    @(posedge clk);
    #1;

    // Reset held with every requester asking.
    for (int c = 0; c < 2; c++) begin
      rst_h = 1'b1;
      req_i = '1;
      step(g);
      chk("rst_gnt", 64'(g), 64'(0));
    end
    idle();
    chk("rst_empty", 64'(empty_o), 64'(1));
    chk("rst_count", 64'(count_o), 64'(0));
    chk("rst_rvalid", 64'(rvalid_o), 64'(0));

    // Single-requester sequence.
    idle(); set_req(0, 2'b00, 3); step(g);
    idle(); set_req(0, 2'b00, 4); step(g);
    idle(); set_req(0, 2'b01, 6); step(g);
    idle(); set_req(0, 2'b11, 0); step(g);
    chk("s2_rd6", 64'(rdata_o), 64'(6));
    chk("s2_rv", 64'(rvalid_o), 64'(1));
    idle(); set_req(0, 2'b10, 0); step(g);
    chk("s2_rd4", 64'(rdata_o), 64'(4));
    chk("s2_rid", 64'(rid_o), 64'(0));
    chk("s2_cnt", 64'(count_o), 64'(1));
    idle(); set_req(0, 2'b11, 0); step(g);
    chk("s2_front", 64'(rdata_o), 64'(3));

    // Round-robin among four continuous pushers.
    do_reset();
    for (int k = 0; k < 4; k++)
      set_req(k, 2'b00, 32'(100 + k));
    for (int c = 0; c < 5; c++) begin
      logic [3:0] eg;
      eg = 4'b0001 << (c % 4);
      step(g);
      chk("rr_seq", 64'(g), 64'(eg));
    end
    idle();
    for (int c = 0; c < 5; c++) begin
      set_req(0, 2'b11, 0);
      step(g);
      chk("rr_pop", 64'(rdata_o), 64'(100 + (c % 4)));
    end

    // Full: push masked, pop proceeds first.
    do_reset();
    for (int c = 0; c < 16; c++) begin
      idle(); set_req(3, 2'b00, 32'(200 + c)); step(g);
    end
    idle();
    chk("f_full", 64'(full_o), 64'(1));
    set_req(0, 2'b00, 32'h55);
    set_req(1, 2'b11, 0);
    step(g);
    chk("f_gnt1", 64'(g), 64'(4'b0010));
    chk("f_rd", 64'(rdata_o), 64'(200));
    idle(); set_req(0, 2'b00, 32'h55);
    step(g);
    chk("f_gnt0", 64'(g), 64'(4'b0001));
    chk("f_cnt", 64'(count_o), 64'(16));
    idle();

    // Empty: pop masked, push proceeds first.
    do_reset();
    set_req(2, 2'b10, 0);
    set_req(3, 2'b00, 9);
    step(g);
    chk("e_gnt3", 64'(g), 64'(4'b1000));
    idle(); set_req(2, 2'b10, 0);
    step(g);
    chk("e_gnt2", 64'(g), 64'(4'b0100));
    chk("e_rd", 64'(rdata_o), 64'(9));
    chk("e_rid", 64'(rid_o), 64'(2));
    idle();

    // Wrap across the end of the buffer, then flush.
    do_reset();
    for (int c = 0; c < 40; c++) begin
      idle(); set_req(0, 2'b00, 32'(1000 + c)); step(g);
      idle(); set_req(0, 2'b11, 0); step(g);
      chk("w_rd", 64'(rdata_o), 64'(1000 + c));
    end
    for (int c = 0; c < 5; c++) begin
      idle(); set_req(1, 2'b01, 32'(c)); step(g);
    end
    idle();
    req_i = '1;
    flush_i = 1'b1;
    step(g);
    chk("fl_gnt", 64'(g), 64'(0));
    chk("fl_cnt", 64'(count_o), 64'(0));
    idle();

    // Randomized traffic in fill/drain phases.
    for (int c = 0; c < 3000; c++) begin
      pop_pct = ((c / 200) % 2 == 0) ? 25 : 75;
      idle();
      for (int k = 0; k < 4; k++) begin
        if ($urandom_range(0, 99) < 60) begin
          logic [1:0] op;
          op[1] = ($urandom_range(0, 99) < pop_pct);
          op[0] = 1'($urandom_range(0, 1));
          set_req(k, op, $urandom);
        end
      end
      flush_i = ($urandom_range(0, 99) == 0);
      rst_h   = ($urandom_range(0, 499) == 0);
      step(g);
    end
    idle();
    step(g);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
